// File: rtl/layer_ram_fetch_pkg.sv
// rtl/layer_ram_fetch_pkg.sv - shared types, width defaults and byte-lane helper for the layer RAM fetch stage.
package layer_ram_fetch_pkg;

  localparam int ADDR_WIDTH_DEF = 27;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic                      is_sprite;
    logic                      timeout;
  } fetch_result_t;

  // Sprites take the whole word; text takes the byte picked by the odd-address bit.
  function automatic logic [DATA_WIDTH_DEF-1:0] lane_select(
    input logic [DATA_WIDTH_DEF-1:0] word,
    input logic                      sprite,
    input logic                      lane
  );
    if (sprite) return word;
    return {{(DATA_WIDTH_DEF-8){1'b0}}, (lane ? word[15:8] : word[7:0])};
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - loadable up-counter with clear/enable; tc flags the step that reaches TIMEOUT_CYCLES.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  load,
  input  logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   load_value,
  input  logic                                  en,
  output logic                                  tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Asserted in the cycle whose increment would make the count equal TIMEOUT_CYCLES.
  assign tc = en && (count == TC_VAL);

endmodule

// File: rtl/layer_ram_fetch.sv
// rtl/layer_ram_fetch.sv - adds layer base to offset, issues one pixel RAM read, returns word or text byte.
// Optional one-word result cache enabled by LAYER_FETCH_CACHE_EN.
module layer_ram_fetch
  import layer_ram_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calc_valid,
  output logic                  calc_ready,
  input  logic                  is_sprite,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] offset_bytes,
  input  logic                  frame_start,
  output logic                  ram_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_ack,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_is_sprite,
  output logic                  fetch_timeout
);

  fetch_state_t              state;
  fetch_result_t             result;
  logic [ADDR_WIDTH-1:0]     addr_sum;
  logic                      cur_sprite;
  logic                      cur_lane;
  logic                      cnt_clear;
  logic                      cnt_en;
  logic                      cnt_tc;
  logic                      cache_hit;
  logic [DATA_WIDTH_DEF-1:0] cache_word;

  assign addr_sum        = base_addr + offset_bytes;
  assign cnt_clear       = (state == ST_IDLE);
  assign cnt_en          = (state == ST_REQ) && !ram_ack;
  assign fetch_data      = DATA_WIDTH'(result.data);
  assign fetch_is_sprite = result.is_sprite;
  assign fetch_timeout   = result.timeout;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .load      (1'b0),
    .load_value('0),
    .en        (cnt_en),
    .tc        (cnt_tc)
  );

`ifdef LAYER_FETCH_CACHE_EN
  logic                  cache_valid;
  logic [ADDR_WIDTH-2:0] cache_tag;

  // frame_start wins over a same-cycle fill so a new frame never sees old pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_word  <= '0;
    end else if (frame_start) begin
      cache_valid <= 1'b0;
    end else if (state == ST_REQ && ram_ack) begin
      cache_valid <= 1'b1;
      cache_tag   <= ram_addr[ADDR_WIDTH-1:1];
      cache_word  <= DATA_WIDTH_DEF'(ram_rdata);
    end
  end

  assign cache_hit = cache_valid && !frame_start && (cache_tag == addr_sum[ADDR_WIDTH-1:1]);
`else
  logic frame_start_unused;
  assign frame_start_unused = frame_start;
  assign cache_word         = '0;
  assign cache_hit          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      calc_ready  <= 1'b1;
      ram_req     <= 1'b0;
      ram_addr    <= '0;
      fetch_valid <= 1'b0;
      result      <= '0;
      cur_sprite  <= 1'b0;
      cur_lane    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (calc_valid) begin
            cur_sprite <= is_sprite;
            cur_lane   <= addr_sum[0];
            calc_ready <= 1'b0;
            if (cache_hit) begin
              state       <= ST_RESP;
              fetch_valid <= 1'b1;
              result      <= '{lane_select(cache_word, is_sprite, addr_sum[0]), is_sprite, 1'b0};
            end else begin
              state    <= ST_REQ;
              ram_req  <= 1'b1;
              ram_addr <= {addr_sum[ADDR_WIDTH-1:1], 1'b0};
            end
          end
        end
        ST_REQ: begin
          if (ram_ack) begin
            state       <= ST_RESP;
            ram_req     <= 1'b0;
            fetch_valid <= 1'b1;
            result      <= '{lane_select(DATA_WIDTH_DEF'(ram_rdata), cur_sprite, cur_lane), cur_sprite, 1'b0};
          end else if (cnt_tc) begin
            state       <= ST_RESP;
            ram_req     <= 1'b0;
            fetch_valid <= 1'b1;
            result      <= '{'0, cur_sprite, 1'b1};
          end
        end
        ST_RESP: begin
          if (fetch_ready) begin
            state       <= ST_IDLE;
            fetch_valid <= 1'b0;
            calc_ready  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/layer_ram_fetch.md
# layer_ram_fetch

Fetch stage sitting directly downstream of the ALU-stage RAM address calculator in the GPU pipe. Accepts a byte offset (sprite pixel offset or text character index), adds the layer's base address, and issues one 16-bit read to pixel RAM over a req/ack handshake. Returns the sprite pixel word or the text character byte to the next pipe stage over a valid/ready handshake. A timeout guards against a stalled RAM.

## Interface
- ADDR_WIDTH, 27, byte-address width; matches the address calculator's offset width.
- DATA_WIDTH, 16, RAM word width: one sprite pixel.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for `ram_ack`; minimum 1.

- clk  in  1  pipe clock.
- rst  in  1  reset, asynchronous, active-low.
- calc_valid  in  1  offset available; driven from the calculator's `rdy`.
- calc_ready  out  1  block can accept an offset.
- is_sprite  in  1  1 = sprite pixel fetch, 0 = text character fetch. Sampled with the offset.
- base_addr  in  ADDR_WIDTH  layer base byte address. Sampled with the offset.
- offset_bytes  in  ADDR_WIDTH  offset from the calculator.
- frame_start  in  1  single-cycle pulse at the start of each frame.
- ram_req  out  1  read request.
- ram_addr  out  ADDR_WIDTH  word-aligned byte address; bit 0 is always 0.
- ram_ack  in  1  read data valid this cycle.
- ram_rdata  in  DATA_WIDTH  read word.
- fetch_valid  out  1  result available.
- fetch_ready  in  1  downstream accepts the result.
- fetch_data  out  DATA_WIDTH  pixel word, or character byte zero-extended.
- fetch_is_sprite  out  1  type of the result.
- fetch_timeout  out  1  result was produced by a timeout; `fetch_data` is 0.

## Operation
- Address:
  - `addr = (base_addr + offset_bytes) mod 2^ADDR_WIDTH`.
  - `ram_addr = {addr[ADDR_WIDTH-1:1], 1'b0}`.
  - Sprite fetch: `addr[0]` is ignored.
  - Text fetch: `addr[0]` selects the byte lane. 0 selects `rdata[7:0]`, 1 selects `rdata[15:8]`.
- FSM states: IDLE, REQ, RESP.
  - IDLE: `calc_ready=1`. When `calc_valid`, capture `addr`, `is_sprite`, clear the timeout counter, and go to REQ.
  - REQ: `ram_req=1`, `ram_addr` held stable.
    - `ram_ack` in the same cycle: capture and lane-select the data, go to RESP.
    - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, drop `ram_req`, load data 0, set the timeout flag, and go to RESP.
  - RESP: `fetch_valid=1` with data and flags held stable. When `fetch_ready`, go to IDLE.
- No back-to-back accept: `calc_ready` is 0 in REQ and RESP. The upstream holds its offset and `calc_valid` until the transfer.
- `ram_ack` is ignored outside REQ. This includes a late ack after a timeout.
- `frame_start` only affects the cache (see Configuration). It is otherwise ignored.

## Timing
- Reset values:
  - State IDLE.
  - `calc_ready=1` once the FSM is in IDLE.
  - `ram_req=0`, `ram_addr=0`.
  - `fetch_valid=0`, `fetch_data=0`, `fetch_is_sprite=0`, `fetch_timeout=0`.
- Reset mid-operation: `ram_req` and `fetch_valid` drop asynchronously and the in-flight result is discarded.
- Latency:
  - Accept at cycle N, so `ram_req` is high from N+1.
  - Ack at cycle N+1+k (k ≥ 0), so `fetch_valid` is high from N+2+k.
- Minimum accept-to-valid is 2 cycles. Minimum throughput is one fetch per 3 cycles.
- Timeout: with no ack, `ram_req` is high for exactly TIMEOUT_CYCLES cycles, then `fetch_valid` follows on the next cycle.
- `fetch_ready` held high in RESP: `calc_ready` is high on the following cycle.

## Configuration
- `LAYER_FETCH_CACHE_EN` defined:
  - A one-entry word cache holds the last successful (non-timeout) RAM word and its `ram_addr`.
  - In IDLE, if `calc_valid` and the cache is valid and the word address matches, go directly to RESP with the lane-selected cached data. No `ram_req` is issued, so accept-to-valid is 1 cycle.
  - The cache is invalidated by reset and by `frame_start`. If `frame_start` and an accept coincide, the access misses.
- Not defined: no cache. Every accept issues a RAM read, and `frame_start` is unused.

## Structure
- Shared GPU package holds:
  - The FSM state enum (IDLE, REQ, RESP).
  - The `ADDR_WIDTH` and `DATA_WIDTH` defaults.
  - A `fetch_result_t` struct with fields data, is_sprite, timeout.
- Natural sub-module: `fetch_timeout_counter`. It is a loadable up-counter with clear, enable, and terminal-count output at TIMEOUT_CYCLES.

## Test plan
- Sprite fetch: base 0x100, offset 0x24, ack after 3 cycles, rdata 0xBEEF. Expect `ram_addr` 0x124, `fetch_data` 0xBEEF, `fetch_is_sprite=1`, `fetch_valid` 5 cycles after accept.
- Text byte lanes:
  - base 0x200, offset 5, rdata 0x4142: `ram_addr` 0x204, `fetch_data` 0x0041.
  - offset 4: `fetch_data` 0x0042.
- Timeout: TIMEOUT_CYCLES=4, never ack. Expect `ram_req` high exactly 4 cycles, `fetch_timeout=1`, `fetch_data=0`. A late ack is ignored.
- Backpressure and wrap:
  - Hold `fetch_ready=0` for 10 cycles: outputs stable, `calc_ready=0`, no new `ram_req`.
  - base 0x7FFFFFE, offset 4: `ram_addr` 0x0000002.
- Reset mid-REQ: assert `rst` low during REQ. `ram_req` drops immediately, `fetch_valid=0`, and the next fetch after reset completes normally.
- With `LAYER_FETCH_CACHE_EN`:
  - Repeat the same word address: no `ram_req`, 1-cycle latency.
  - Pulse `frame_start`, then repeat the same address: a RAM read is issued.
